usb_device_responder: RTL

- Device-side (function-end) protocol responder for the USB-like link.
- Consumes decoded, CRC-checked packets from a device-side receive datapath and answers with handshake or DATA0 packets through a device-side transmit datapath.
- Implements a small addressable memory: endpoint ENDP_ADDR sets a pointer, endpoint ENDP_DATA reads and writes the word at that pointer.
- Serves as the bench/device partner for the host datapath and protocol FSM.

---
 rtl/usb_pkg.sv | 33 +++
 rtl/resp_mem.sv | 24 ++
 rtl/usb_device_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared PIDs, packet field positions and responder states for the USB-like link
package usb_pkg;
    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    localparam int PID_HI     = 90;
    localparam int PID_LO     = 83;
    localparam int ADDR_HI    = 82;
    localparam int ADDR_LO    = 76;
    localparam int ENDP_HI    = 75;
    localparam int ENDP_LO    = 72;
    localparam int PAYLOAD_HI = 82;
    localparam int PAYLOAD_LO = 19;

    localparam logic [7:0] SYNC = 8'h01;

    function automatic logic [7:0] pid_byte(pid_t p);
        return {~p, p};
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SEND_HS,
        SEND_DATA,
        WAIT_ACK
    } resp_state_t;
endpackage

// File: rtl/resp_mem.sv
// resp_mem: 64-bit register file, cleared on reset, one write port, combinational read
module resp_mem #(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [PW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/usb_device_responder.sv
// usb_device_responder: device-side responder answering OUT/IN tokens with handshakes or DATA0,
// backed by a small memory addressed through a pointer endpoint.
module usb_device_responder
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ENDP_ADDR = 4'd4,
    parameter logic [3:0] ENDP_DATA = 4'd8,
    parameter int         MEM_DEPTH = 16,
    parameter int         TIMEOUT   = 255,
    localparam int        PW        = $clog2(MEM_DEPTH),
    localparam int        TW        = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [98:0]   rx_pkt,
    input  logic          rx_pkt_avail,
    input  logic          rx_data_good,
    output logic [98:0]   tx_pkt,
    output logic          tx_pkt_avail,
    input  logic          tx_ready,
    output logic [PW-1:0] mem_ptr,
    output logic          xfer_done,
    output logic          timeout
);
    resp_state_t   state, state_n;
    pid_t          hs, hs_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    endp, endp_n;
    logic [PW-1:0] ptr_n;
    logic [98:0]   tx_n;
    logic          txa_n, xd_n, to_n, we;
    logic [63:0]   rdata;

    logic [7:0]  rx_pb;
    logic [3:0]  rx_pid, rx_endp;
    logic [6:0]  rx_addr;
    logic [63:0] payload;
    logic        pid_ok, tok, tok_out, tok_in, data_rx, ack_rx, nak_rx, expired;
    logic        unused_bits;

    assign rx_pb       = rx_pkt[PID_HI:PID_LO];
    assign rx_pid      = rx_pb[3:0];
    assign rx_addr     = rx_pkt[ADDR_HI:ADDR_LO];
    assign rx_endp     = rx_pkt[ENDP_HI:ENDP_LO];
    assign payload     = rx_pkt[PAYLOAD_HI:PAYLOAD_LO];
    assign unused_bits = ^{rx_pkt[98:91], rx_pkt[18:0]};
    assign pid_ok      = rx_pb[7:4] == ~rx_pb[3:0];
    assign expired     = timer == TW'(TIMEOUT);

    // A token counts only when it is intact and addressed to us; where it leads depends on PID/ENDP
    assign tok     = rx_pkt_avail && rx_data_good && pid_ok && rx_addr == DEV_ADDR &&
                     (rx_pid == PID_OUT || rx_pid == PID_IN);
    assign tok_out = tok && rx_pid == PID_OUT && (rx_endp == ENDP_ADDR || rx_endp == ENDP_DATA);
    assign tok_in  = tok && rx_pid == PID_IN && rx_endp == ENDP_DATA;
    assign data_rx = rx_pkt_avail && pid_ok && rx_pid == PID_DATA0;
    assign ack_rx  = rx_pkt_avail && rx_data_good && pid_ok && rx_pid == PID_ACK;
    assign nak_rx  = rx_pkt_avail && (!rx_data_good || (pid_ok && rx_pid == PID_NAK));

    resp_mem #(.DEPTH(MEM_DEPTH), .PW(PW)) u_mem (
        .clk(clk),
        .rst(rst_b),
        .we(we),
        .addr(mem_ptr),
        .wdata(payload),
        .rdata(rdata)
    );

    always_comb begin
        state_n = state;
        hs_n    = hs;
        timer_n = timer;
        endp_n  = endp;
        ptr_n   = mem_ptr;
        tx_n    = tx_pkt;
        txa_n   = 1'b0;
        xd_n    = 1'b0;
        to_n    = 1'b0;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (tok_out) begin
                    state_n = WAIT_DATA;
                    endp_n  = rx_endp;
                    timer_n = '0;
                end else if (tok_in) begin
                    state_n = SEND_DATA;
                end
            end
            WAIT_DATA: begin
                timer_n = expired ? timer : timer + 1'b1;
                if (tok) begin
                    state_n = tok_out ? WAIT_DATA : tok_in ? SEND_DATA : IDLE;
                    endp_n  = rx_endp;
                    timer_n = '0;
                end else if (data_rx && rx_data_good) begin
                    ptr_n   = endp == ENDP_ADDR ? payload[PW-1:0] : mem_ptr;
                    we      = endp == ENDP_DATA;
                    xd_n    = 1'b1;
                    hs_n    = PID_ACK;
                    state_n = SEND_HS;
                end else if (data_rx) begin
                    hs_n    = PID_NAK;
                    state_n = SEND_HS;
                end else if (expired) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            SEND_HS: begin
                if (tx_ready) begin
                    tx_n    = {SYNC, pid_byte(hs), 83'b0};
                    txa_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            SEND_DATA: begin
                if (tx_ready) begin
                    tx_n    = {SYNC, pid_byte(PID_DATA0), rdata, 19'b0};
                    txa_n   = 1'b1;
                    timer_n = '0;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                timer_n = expired ? timer : timer + 1'b1;
                if (ack_rx) begin
                    xd_n    = 1'b1;
                    state_n = IDLE;
                end else if (nak_rx) begin
                    state_n = IDLE;
                end else if (expired) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state        <= IDLE;
            hs           <= PID_ACK;
            timer        <= '0;
            endp         <= '0;
            mem_ptr      <= '0;
            tx_pkt       <= '0;
            tx_pkt_avail <= 1'b0;
            xfer_done    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_n;
            hs           <= hs_n;
            timer        <= timer_n;
            endp         <= endp_n;
            mem_ptr      <= ptr_n;
            tx_pkt       <= tx_n;
            tx_pkt_avail <= txa_n;
            xfer_done    <= xd_n;
            timeout      <= to_n;
        end
    end
endmodule
